// File: rtl/mul_pipe.sv
// -----------------------------------------------------------------------------
// mul_pipe -- pipelined WIDTH x WIDTH multiplier with valid/ready handshakes.
//
// Each accepted operand pair produces an exact 2*WIDTH-bit product, either
// unsigned or two's-complement as selected by in_signed. The product is
// available STAGES advancing cycles after acceptance. A stalled output
// (out_valid high, out_ready low) freezes the whole pipeline.
//
// Ports
//   clk        in   1        single clock, rising edge
//   rst_n      in   1        synchronous active-low reset
//   in_valid   in   1        operand pair valid
//   in_ready   out  1        pair can be accepted this cycle
//   in_a       in   WIDTH    multiplicand
//   in_b       in   WIDTH    multiplier
//   in_signed  in   1        1 = two's-complement operands, 0 = unsigned
//   out_valid  out  1        result valid (registered)
//   out_ready  in   1        consumer takes the result this cycle
//   out_prod   out  2*WIDTH  full-width product (registered)
// -----------------------------------------------------------------------------
module mul_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod
);

    localparam int PW = 2 * WIDTH;

    // Widen an operand to the product width, sign- or zero-extending.
    function automatic logic [PW-1:0] extend_operand(
        input logic [WIDTH-1:0] value,
        input logic             is_signed
    );
        logic [PW-1:0] ext;
        ext = {{WIDTH{is_signed & value[WIDTH-1]}}, value};
        return ext;
    endfunction

    logic              w_stall;
    logic              w_advance;
    logic              w_accept;
    logic [STAGES-1:0] r_valid;
    logic [PW-1:0]     w_ext_a;
    logic [PW-1:0]     w_ext_b;
    logic [PW-1:0]     w_pp_lo;
    logic [WIDTH-1:0]  w_pp_hi;
    logic [PW-1:0]     w_out_prod;

    // The last slot is the only one whose hand-off can be refused.
    assign w_stall   = r_valid[STAGES-1] & ~out_ready;
    assign w_advance = ~w_stall;
    assign w_accept  = in_valid & w_advance;

    assign in_ready  = w_advance;
    assign out_valid = r_valid[STAGES-1];
    assign out_prod  = w_out_prod;

    // Product of the extended operands taken modulo 2^PW is exact for both
    // modes because the true result always fits in PW bits. The multiply is
    // split on the multiplier: ext_a * b_low (full width) plus
    // ext_a * b_high shifted by WIDTH, of which only the low WIDTH bits
    // survive the shift, so a WIDTH x WIDTH multiply suffices there.
    assign w_ext_a = extend_operand(in_a, in_signed);
    assign w_ext_b = extend_operand(in_b, in_signed);
    assign w_pp_lo = w_ext_a * {{WIDTH{1'b0}}, w_ext_b[WIDTH-1:0]};
    assign w_pp_hi = w_ext_a[WIDTH-1:0] * w_ext_b[PW-1:WIDTH];

    // Valid bits: shift one slot per non-stalled cycle, bubble when no transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= {STAGES{1'b0}};
        end else if (w_advance) begin
            r_valid[0] <= w_accept;
            for (int i = 1; i < STAGES; i++) begin
                r_valid[i] <= r_valid[i-1];
            end
        end else begin
            r_valid <= r_valid;
        end
    end

    // Data registers only load from a valid predecessor, so bubbles never
    // overwrite the last slot and out_prod keeps the last delivered result.
    if (STAGES == 1) begin : g_single
        logic [PW-1:0] r_prod;

        // Single slot: partial products are summed before the register.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_prod <= {PW{1'b0}};
            end else if (w_accept) begin
                r_prod <= w_pp_lo + {w_pp_hi, {WIDTH{1'b0}}};
            end else begin
                r_prod <= r_prod;
            end
        end

        assign w_out_prod = r_prod;
    end else begin : g_multi
        logic [PW-1:0]    r_pp_lo;
        logic [WIDTH-1:0] r_pp_hi;
        logic [PW-1:0]    r_prod [1:STAGES-1];

        // Slot 0 captures the two partial products of the accepted pair.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_pp_lo <= {PW{1'b0}};
                r_pp_hi <= {WIDTH{1'b0}};
            end else if (w_accept) begin
                r_pp_lo <= w_pp_lo;
                r_pp_hi <= w_pp_hi;
            end else begin
                r_pp_lo <= r_pp_lo;
                r_pp_hi <= r_pp_hi;
            end
        end

        // Slot 1 completes the product; later slots carry it unchanged.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 1; i < STAGES; i++) begin
                    r_prod[i] <= {PW{1'b0}};
                end
            end else if (w_advance) begin
                if (r_valid[0]) begin
                    r_prod[1] <= r_pp_lo + {r_pp_hi, {WIDTH{1'b0}}};
                end
                for (int i = 2; i < STAGES; i++) begin
                    if (r_valid[i-1]) begin
                        r_prod[i] <= r_prod[i-1];
                    end
                end
            end
        end

        assign w_out_prod = r_prod[STAGES-1];
    end

endmodule

// File: tb/tb_mul_pipe.sv
// -----------------------------------------------------------------------------
// tb_mul_pipe -- self-checking bench for mul_pipe (WIDTH=16, STAGES=4).
// The reference keeps a queue of accepted pairs with their products computed
// by plain integer arithmetic and an age count of advancing cycles; the head
// is expected on the output once its age equals STAGES.
// -----------------------------------------------------------------------------
module tb_mul_pipe;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_prod;

    mul_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] prod;
        int          age;
    } ent_t;

    ent_t        q[$];
    logic [31:0] last_prod = 32'h0;
    int          total = 0;
    int          bad   = 0;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_prod;
    logic        acc;

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input logic sgn);
        longint      x;
        longint      y;
        longint      p;
        logic [63:0] pv;
        x = longint'({48'h0, a});
        y = longint'({48'h0, b});
        if (sgn && a[15]) x = x - 64'sd65536;
        if (sgn && b[15]) y = y - 64'sd65536;
        p  = x * y;
        pv = 64'(p);
        return pv[31:0];
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 4))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample/check at negedge, advance the model, return #1 after posedge.
    task automatic tick(input bit chk);
        bit          exp_v;
        bit          exp_r;
        logic [31:0] exp_p;
        ent_t        e;
        @(negedge clk);
        exp_v = (q.size() > 0) && (q[0].age == STAGES);
        exp_r = !(exp_v && !out_ready);
        exp_p = last_prod;
        if (exp_v) exp_p = q[0].prod;
        s_valid = out_valid;
        s_ready = in_ready;
        s_prod  = out_prod;
        if (chk) begin
            check("out_valid", 32'(out_valid), 32'(exp_v));
            check("in_ready", 32'(in_ready), 32'(exp_r));
            check(exp_v ? "out_prod" : "out_prod_hold", out_prod, exp_p);
        end
        last_prod = exp_p;
        acc = 1'b0;
        if (!rst_n) begin
            q.delete();
            last_prod = 32'h0;
        end else if (exp_r) begin
            if (exp_v) void'(q.pop_front());
            for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
            if (in_valid) begin
                e.prod = ref_mul(in_a, in_b, in_signed);
                e.age  = 1;
                q.push_back(e);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() > 0 && n < 40) begin
            tick(1);
            n++;
        end
        check("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    // Send one pair into an empty pipe and check its exact arrival cycle/value.
    task automatic run_pair(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic sgn, input logic [31:0] exp);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = sgn;
        out_ready = 1'b1;
        tick(1);
        check({tag, "_ready"}, 32'(s_ready), 32'd1);
        in_valid = 1'b0;
        for (int k = 1; k <= STAGES; k++) begin
            tick(1);
            check({tag, "_valid"}, 32'(s_valid), 32'(k == STAGES));
            if (k == STAGES) check(tag, s_prod, exp);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          idx;
        int          got;
        int          cyc;
        int          stalls;
        int          sent;
        int          recv;
        logic [31:0] want;

        // Reset with in_valid asserted: nothing may be accepted.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_a      = 16'h1234;
        in_b      = 16'h5678;
        in_signed = 1'b0;
        out_ready = 1'b1;
        tick(0);
        tick(1);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick(1);
        check("reset_valid", 32'(s_valid), 32'd0);
        check("reset_ready", 32'(s_ready), 32'd1);
        check("reset_prod", s_prod, 32'h0);

        // Directed corner products and latency.
        run_pair("u_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
        run_pair("s_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
        run_pair("s_8000_7fff", 16'h8000, 16'h7FFF, 1'b1, 32'hC0008000);
        run_pair("s_8000_8000", 16'h8000, 16'h8000, 1'b1, 32'h40000000);
        run_pair("u_8000_7fff", 16'h8000, 16'h7FFF, 1'b0, 32'h3FFF8000);
        run_pair("u_8000_8000", 16'h8000, 16'h8000, 1'b0, 32'h40000000);

        // Stream 1..8 times 3 with a three-cycle output stall mid-stream.
        idx = 1; got = 0; cyc = 0; stalls = 0;
        while (got < 8 && cyc < 60) begin
            in_valid  = (idx <= 8);
            in_a      = 16'(idx);
            in_b      = 16'd3;
            in_signed = 1'b0;
            out_ready = !(cyc >= 6 && cyc < 9);
            tick(1);
            if (!s_ready) stalls++;
            if (s_valid && out_ready) begin
                want = 32'(3 * (got + 1));
                check("stream_value", s_prod, want);
                got++;
            end
            if (acc) idx++;
            cyc++;
        end
        check("stream_count", 32'(got), 32'd8);
        check("stream_stall_cycles", 32'(stalls), 32'd3);
        drain();

        // Reset before any of three accepted pairs reaches the output.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_a     = pick();
            in_b     = pick();
            tick(1);
        end
        rst_n = 1'b0;
        tick(1);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            check("flush_valid", 32'(s_valid), 32'd0);
            check("flush_prod", s_prod, 32'h0);
            check("flush_ready", 32'(s_ready), 32'd1);
        end

        // Pair accepted on the first edge after reset release.
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick(1);
        rst_n = 1'b1;
        run_pair("post_reset", 16'h0101, 16'h0003, 1'b0, 32'h00000303);

        // Sustained throughput with both handshakes held high.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            in_a      = pick();
            in_b      = pick();
            in_signed = 1'($urandom_range(0, 1));
            tick(1);
            if (k >= STAGES) check("thru_valid", 32'(s_valid), 32'd1);
        end
        drain();

        // Randomised mixed-mode traffic with random handshakes.
        sent = 0; recv = 0; cyc = 0;
        while ((sent < 10000 || q.size() > 0) && cyc < 80000) begin
            in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_a      = pick();
            in_b      = pick();
            in_signed = 1'($urandom_range(0, 1));
            tick(1);
            if (acc) sent++;
            if (s_valid && out_ready) recv++;
            cyc++;
        end
        check("rand_results", 32'(recv), 32'd10000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_pipe.md
MUL_PIPE -- requirements
Module: mul_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; legal range 2..32.
REQ-002 Parameter STAGES, default 4, pipeline depth (accept-to-result latency in cycles); legal range 1..8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-005 in_valid  input  1  operand pair valid.
REQ-006 in_ready  output  1  block can accept operands this cycle.
REQ-007 in_a  input  WIDTH  multiplicand.
REQ-008 in_b  input  WIDTH  multiplier.
REQ-009 in_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with the operands.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result this cycle.
REQ-012 out_prod  output  2*WIDTH  full-width product.

Function
REQ-013 Input transfer occurs when in_valid and in_ready are both 1 on a rising edge; output transfer occurs when out_valid and out_ready are both 1.
REQ-014 Pipeline holds STAGES registered slots, each with a valid bit; slot STAGES-1 drives out_valid and out_prod directly from registers.
REQ-015 stall = out_valid and not out_ready; in_ready = not stall (combinational; no dependence on in_valid).
REQ-016 When stall = 0, all slots advance one position per cycle; slot 0 loads the accepted input, or a bubble (valid = 0) if no transfer occurs.
REQ-017 When stall = 1, every slot, including valid bits, holds its value; no input is accepted.
REQ-018 Latency: a pair accepted in cycle N appears on out_prod with out_valid = 1 in cycle N+STAGES, provided no stall occurs in between; each stall cycle adds one cycle.
REQ-019 Throughput: one result per cycle sustained while in_valid = 1 and out_ready = 1.
REQ-020 Unsigned mode: out_prod = zero-extended in_a times zero-extended in_b, exact in 2*WIDTH bits; never truncated.
REQ-021 Signed mode: out_prod = sign-extended in_a times sign-extended in_b, exact two's-complement result in 2*WIDTH bits, including most-negative times most-negative.
REQ-022 Results leave in acceptance order; no loss, duplication or reordering under any out_ready pattern.
REQ-023 The multiply may be split across stages, but each slot's result depends only on its own captured operands and mode bit.
REQ-024 Bubble slots carry don't-care data, but out_prod retains its last value while out_valid = 0 after the first result.
REQ-025 in_ready is 1 whenever out_valid = 0, even if the pipeline holds in-flight valid slots (bubble compression not required).
REQ-026 When STAGES = 1, the block behaves as a single registered skid-free stage under the same rules.

Reset
REQ-027 While rst_n = 0 at a rising edge, all slot valid bits clear to 0, and all slot data registers and out_prod clear to 0.
REQ-028 During and immediately after reset: out_valid = 0 and in_ready = 1; any in_valid asserted in a reset cycle is not accepted.
REQ-029 Reset asserted mid-operation discards all in-flight results; none appear after rst_n returns to 1.
REQ-030 Operation resumes on the first rising edge with rst_n = 1; a pair accepted on that edge appears STAGES cycles later.

Verification (WIDTH=16, STAGES=4)
REQ-031 Unsigned: a=0xFFFF, b=0xFFFF, in_signed=0, out_ready=1 -> out_prod=0xFFFE0001 with out_valid=1 exactly 4 cycles after acceptance.
REQ-032 Signed: (0xFFFF, 0xFFFF) -> 0x00000001; (0x8000, 0x7FFF) -> 0xC0008000; (0x8000, 0x8000) -> 0x40000000; the same pairs unsigned give 0xFFFE0001, 0x3FFF8000 and 0x40000000.
REQ-033 Stream a=1..8, b=3 on consecutive cycles with out_ready=0 for 3 cycles mid-stream -> outputs 3,6,...,24 in order, none lost or duplicated, in_ready=0 exactly in the stall cycles.
REQ-034 Accept 3 pairs, assert rst_n=0 for 1 cycle before any output -> out_valid stays 0 for 8 following cycles, out_prod=0, in_ready=1.
REQ-035 Random mixed-mode stimulus, 10k pairs, random in_valid/out_ready -> scoreboard matches exact 32-bit products and order; 1 result/cycle whenever both valid and ready are held high.
